ser_2_par: RTL and testbench
============================

SER_2_PAR -- requirements
Module: ser_2_par

Interface
REQ-001 SHALL have parameter WIDTH, default 8; output word width, legal 2..64.
REQ-002 SHALL have parameter LSB_FIRST, default 1; 1 = first received bit lands in bit 0, 0 = first received bit lands in bit WIDTH-1.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  1  serial data bit from upstream.
REQ-006 SHALL have port din_vld  input  1  upstream bit valid.
REQ-007 SHALL have port din_rdy  input  1  downstream ready for dout.
REQ-008 SHALL have port dout  output  WIDTH  assembled parallel word, registered.
REQ-009 SHALL have port dout_vld  output  1  dout valid, registered.
REQ-010 SHALL have port dout_rdy  output  1  block ready to accept a serial bit.

Function
REQ-011 SHALL define wr_en = din_vld & dout_rdy (bit accepted) and rd_en = dout_vld & din_rdy (word consumed).
REQ-012 SHALL hold an assembly register (WIDTH bits), bit counter cnt (0..WIDTH-1, $clog2(WIDTH) bits) and flag asm_full.
REQ-013 SHALL write an accepted bit to assembly position cnt when LSB_FIRST=1, WIDTH-1-cnt when LSB_FIRST=0; cnt increments per wr_en and wraps WIDTH-1 -> 0.
REQ-014 SHALL, on wr_en with cnt=WIDTH-1 and output slot free (dout_vld=0 or rd_en), load dout with the complete word including the current bit and assert dout_vld the next cycle (latency 1 cycle from last bit).
REQ-015 SHALL, on wr_en with cnt=WIDTH-1 and output slot occupied with no rd_en, set asm_full=1 and retain the word.
REQ-016 SHALL, while asm_full=1 and rd_en, move the assembled word to dout, keep dout_vld=1, and clear asm_full.
REQ-017 SHALL clear dout_vld on rd_en when no new word is loaded that cycle.
REQ-018 SHALL drive dout_rdy = ~asm_full combinationally; no new bit accepted while a complete word waits.
REQ-019 SHALL sustain one word per WIDTH cycles with no bubbles when din_vld and din_rdy are held high.
REQ-020 SHALL hold dout stable while dout_vld=1 and din_rdy=0.
REQ-021 SHALL ignore din when din_vld=0; cnt and assembly register unchanged.

Reset
REQ-022 SHALL, on rst=1 at a clock edge, set cnt=0, asm_full=0, assembly register=0, dout=0, dout_vld=0; dout_rdy=1 the cycle after.
REQ-023 SHALL discard any partially assembled or pending word on reset mid-operation; no word emitted for bits received before reset.

Configuration
REQ-024 SHALL compile a flush feature when macro SER_2_PAR_FLUSH_EN is defined.
REQ-025 With SER_2_PAR_FLUSH_EN: SHALL add ports din_last (input 1, last bit of frame) and dout_last (output 1, registered, travels with dout, reset 0).
REQ-026 With SER_2_PAR_FLUSH_EN: wr_en with din_last=1 SHALL complete the word at any cnt, zero unfilled positions, reset cnt to 0, and set dout_last=1 with that word; all other words carry dout_last=0; slot-occupied case follows REQ-015/016.
REQ-027 Without SER_2_PAR_FLUSH_EN: ports din_last/dout_last SHALL be absent and words complete only at cnt=WIDTH-1.

Verification
REQ-028 WIDTH=8, LSB_FIRST=1, din_rdy=1, bits 1,0,1,0,0,1,0,1 on consecutive cycles -> dout=0xA5, dout_vld=1 one cycle after 8th bit, for exactly 1 cycle.
REQ-029 WIDTH=8, LSB_FIRST=0, same bit sequence -> dout=0xA5 (MSB-first order); back-to-back second word 0x3C follows with no idle cycle on dout_rdy.
REQ-030 din_rdy=0, stream 16 bits (0x11 then 0x22) -> dout=0x11 held, dout_rdy=0 after 16th bit; raise din_rdy -> 0x11 consumed, dout=0x22 next cycle, dout_rdy=1.
REQ-031 rst=1 after 5 bits, then 8 bits of 0xFF -> only dout=0xFF emitted; no word from the pre-reset bits.
REQ-032 SER_2_PAR_FLUSH_EN, LSB_FIRST=1: bits 1,1,0 with din_last on third -> dout=0x03, dout_last=1; next full word has dout_last=0.
REQ-033 din_vld toggled 1/0 every cycle across 8 bits -> same word as gap-free case, dout_vld only after 8th accepted bit.

Source files
------------

// File: rtl/ser_2_par_if.sv
// Serial-in / parallel-out bus bundle for ser_2_par.
// SER_2_PAR_FLUSH_EN adds the din_last/dout_last frame markers.
interface ser_2_par_if #(
   parameter int WIDTH = 8
);
   logic             din;
   logic             din_vld;
   logic             din_rdy;
   logic [WIDTH-1:0] dout;
   logic             dout_vld;
   logic             dout_rdy;
`ifdef SER_2_PAR_FLUSH_EN
   logic             din_last;
   logic             dout_last;

   modport master (
      output din,
      output din_vld,
      output din_last,
      output din_rdy,
      input  dout,
      input  dout_vld,
      input  dout_last,
      input  dout_rdy
   );

   modport slave (
      input  din,
      input  din_vld,
      input  din_last,
      input  din_rdy,
      output dout,
      output dout_vld,
      output dout_last,
      output dout_rdy
   );
`else
   modport master (
      output din,
      output din_vld,
      output din_rdy,
      input  dout,
      input  dout_vld,
      input  dout_rdy
   );

   modport slave (
      input  din,
      input  din_vld,
      input  din_rdy,
      output dout,
      output dout_vld,
      output dout_rdy
   );
`endif
endinterface

// File: rtl/ser_2_par.sv
// Serial-to-parallel converter with one-word skid buffer.
// Define SER_2_PAR_FLUSH_EN to enable din_last early word completion.
module ser_2_par #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   ser_2_par_if.slave  bus
);

   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH - 1);

   typedef enum logic {
      S_FILL,
      S_FULL
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [CW-1:0]    cnt_q;
   logic [CW-1:0]    cnt_d;
   logic [CW-1:0]    pos;
   logic [WIDTH-1:0] asm_q;
   logic [WIDTH-1:0] asm_d;
   logic [WIDTH-1:0] word_nxt;
   logic [WIDTH-1:0] dout_q;
   logic [WIDTH-1:0] dout_d;
   logic             vld_q;
   logic             vld_d;
   logic             asm_full;
   logic             wr_en;
   logic             rd_en;
   logic             slot_free;
   logic             bit_last;
   logic             word_done;
`ifdef SER_2_PAR_FLUSH_EN
   logic             last_q;
   logic             last_d;
   logic             asm_last_q;
   logic             asm_last_d;

   assign bit_last      = bus.din_last;
   assign bus.dout_last = last_q;
`else
   assign bit_last      = 1'b0;
`endif

   assign asm_full     = (state_q == S_FULL);
   assign bus.dout_rdy = ~asm_full;
   assign bus.dout     = dout_q;
   assign bus.dout_vld = vld_q;

   assign wr_en     = bus.din_vld & ~asm_full;
   assign rd_en     = vld_q & bus.din_rdy;
   assign slot_free = ~vld_q | bus.din_rdy;
   assign pos       = LSB_FIRST ? cnt_q : CNT_MAX - cnt_q;
   assign word_done = wr_en & ((cnt_q == CNT_MAX) | bit_last);

   // asm_q is cleared after every word, so unfilled bits read as zero
   always_comb begin
      word_nxt      = asm_q;
      word_nxt[pos] = bus.din;
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      asm_d      = asm_q;
      dout_d     = dout_q;
      vld_d      = vld_q;
`ifdef SER_2_PAR_FLUSH_EN
      last_d     = last_q;
      asm_last_d = asm_last_q;
`endif
      if (wr_en) begin
         cnt_d = word_done ? '0 : cnt_q + CW'(1);
      end
      unique case (state_q)
         S_FULL: begin
            if (rd_en) begin
               dout_d  = asm_q;
               vld_d   = 1'b1;
               asm_d   = '0;
               state_d = S_FILL;
`ifdef SER_2_PAR_FLUSH_EN
               last_d  = asm_last_q;
`endif
            end
         end
         S_FILL: begin
            if (word_done && slot_free) begin
               dout_d     = word_nxt;
               vld_d      = 1'b1;
               asm_d      = '0;
`ifdef SER_2_PAR_FLUSH_EN
               last_d     = bit_last;
`endif
            end else if (word_done) begin
               asm_d      = word_nxt;
               state_d    = S_FULL;
`ifdef SER_2_PAR_FLUSH_EN
               asm_last_d = bit_last;
`endif
            end else begin
               if (wr_en) asm_d = word_nxt;
               if (rd_en) vld_d = 1'b0;
            end
         end
         default: state_d = S_FILL;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_FILL;
         cnt_q      <= '0;
         asm_q      <= '0;
         dout_q     <= '0;
         vld_q      <= 1'b0;
`ifdef SER_2_PAR_FLUSH_EN
         last_q     <= 1'b0;
         asm_last_q <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         asm_q      <= asm_d;
         dout_q     <= dout_d;
         vld_q      <= vld_d;
`ifdef SER_2_PAR_FLUSH_EN
         last_q     <= last_d;
         asm_last_q <= asm_last_d;
`endif
      end
   end

endmodule

// File: tb/tb_ser_2_par.sv
// Scoreboard bench for ser_2_par: LSB-first and MSB-first
// instances share one stimulus stream.
module tb_ser_2_par;

   localparam int W = 8;

   typedef bit bq_t[$];

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   ser_2_par_if #(.WIDTH(W)) ifa ();
   ser_2_par_if #(.WIDTH(W)) ifb ();

   ser_2_par #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa.slave)
   );

   ser_2_par #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb.slave)
   );

   int tests   = 0;
   int fails   = 0;
   int retries = 0;
   bit stuck   = 1'b0;
   bit mon_en  = 1'b0;
   bit acc;
   logic rdy_drv;

   logic [W-1:0] expa[$];
   logic [W-1:0] expb[$];
   logic [W-1:0] gota[$];
   logic [W-1:0] gotb[$];
   bit           lasta[$];
   bit           lastb[$];
   bq_t          bqa;
   bq_t          bqb;

   task automatic chk(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  name, act, exp, $time);
      end
   endtask

   // Reference packing: k-th accepted bit of a word lands at k or W-1-k
   function automatic logic [W-1:0] pack(input bq_t bits, input bit lsb);
      logic [W-1:0] w;
      w = '0;
      for (int i = 0; i < bits.size(); i++)
         w[lsb ? i : W-1-i] = bits[i];
      return w;
   endfunction

   task automatic cycle(input bit d, input bit v, input bit l,
                        input bit r, output bit accepted);
      @(posedge clk);
      #1;
      rst         = r;
      ifa.din     = d;
      ifb.din     = d;
      ifa.din_vld = v;
      ifb.din_vld = v;
      ifa.din_rdy = rdy_drv;
      ifb.din_rdy = rdy_drv;
`ifdef SER_2_PAR_FLUSH_EN
      ifa.din_last = l;
      ifb.din_last = l;
`endif
      @(negedge clk);
      #1;
      accepted = v & ifa.dout_rdy & ~r;
      if (r) begin
         expa.delete();
         expb.delete();
         lasta.delete();
         lastb.delete();
         bqa.delete();
         bqb.delete();
      end else begin
         if (v && ifa.dout_rdy) begin
            bqa.push_back(d);
            if (bqa.size() == W || l) begin
               expa.push_back(pack(bqa, 1'b1));
               lasta.push_back(l);
               bqa.delete();
            end
         end
         if (v && ifb.dout_rdy) begin
            bqb.push_back(d);
            if (bqb.size() == W || l) begin
               expb.push_back(pack(bqb, 1'b0));
               lastb.push_back(l);
               bqb.delete();
            end
         end
      end
   endtask

   task automatic idle(input int n);
      bit a;
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, a);
   endtask

   task automatic send_bit(input bit d, input bit l);
      bit a;
      if (stuck) return;
      for (int i = 0; i < 64; i++) begin
         cycle(d, 1'b1, l, 1'b0, a);
         if (a) return;
         retries++;
      end
      stuck = 1'b1;
      chk("send_timeout", 64'd0, 64'd1);
   endtask

   task automatic send_word(input logic [W-1:0] val);
      for (int i = 0; i < W; i++) send_bit(val[i], 1'b0);
   endtask

   task automatic clear_got();
      gota.delete();
      gotb.delete();
   endtask

   always @(negedge clk) begin
      if (mon_en) begin
         chk("a_rdy", 64'(ifa.dout_rdy), 64'(expa.size() < 2));
         chk("a_vld", 64'(ifa.dout_vld), 64'(expa.size() > 0));
         if (expa.size() > 0) begin
            chk("a_dout", 64'(ifa.dout), 64'(expa[0]));
`ifdef SER_2_PAR_FLUSH_EN
            chk("a_last", 64'(ifa.dout_last), 64'(lasta[0]));
`endif
            if (ifa.din_rdy) begin
               gota.push_back(ifa.dout);
               void'(expa.pop_front());
               void'(lasta.pop_front());
            end
         end
         chk("b_rdy", 64'(ifb.dout_rdy), 64'(expb.size() < 2));
         chk("b_vld", 64'(ifb.dout_vld), 64'(expb.size() > 0));
         if (expb.size() > 0) begin
            chk("b_dout", 64'(ifb.dout), 64'(expb[0]));
`ifdef SER_2_PAR_FLUSH_EN
            chk("b_last", 64'(ifb.dout_last), 64'(lastb[0]));
`endif
            if (ifb.din_rdy) begin
               gotb.push_back(ifb.dout);
               void'(expb.pop_front());
               void'(lastb.pop_front());
            end
         end
      end
   end

   initial begin
      logic [W-1:0] pre;
      int r0;
      rst         = 1'b1;
      rdy_drv     = 1'b1;
      ifa.din     = 1'b0;
      ifb.din     = 1'b0;
      ifa.din_vld = 1'b0;
      ifb.din_vld = 1'b0;
      ifa.din_rdy = 1'b1;
      ifb.din_rdy = 1'b1;
`ifdef SER_2_PAR_FLUSH_EN
      ifa.din_last = 1'b0;
      ifb.din_last = 1'b0;
`endif
      for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
      mon_en = 1'b1;
      idle(1);
      chk("rst_dout_a", 64'(ifa.dout), 64'd0);
      chk("rst_vld_a", 64'(ifa.dout_vld), 64'd0);
      chk("rst_rdy_a", 64'(ifa.dout_rdy), 64'd1);
      chk("rst_dout_b", 64'(ifb.dout), 64'd0);

      // single word, both bit orders
      clear_got();
      pre = 8'hA5;
      for (int i = 0; i < W; i++) send_bit(pre[i], 1'b0);
      idle(3);
      chk("w1_cnt", 64'(gota.size()), 64'd1);
      chk("w1_a", 64'(gota[0]), 64'hA5);
      chk("w1_b", 64'(gotb[0]), 64'hA5);

      // back-to-back words, no stall expected
      clear_got();
      r0 = retries;
      send_word(8'hA5);
      send_word(8'h3C);
      chk("b2b_retries", 64'(retries - r0), 64'd0);
      idle(3);
      chk("b2b_a0", 64'(gota[0]), 64'hA5);
      chk("b2b_a1", 64'(gota[1]), 64'h3C);
      chk("b2b_b1", 64'(gotb[1]), 64'h3C);

      // backpressure: two words held, then released
      clear_got();
      rdy_drv = 1'b0;
      send_word(8'h11);
      send_word(8'h22);
      idle(2);
      chk("bp_hold", 64'(ifa.dout), 64'h11);
      chk("bp_rdy0", 64'(ifa.dout_rdy), 64'd0);
      rdy_drv = 1'b1;
      idle(2);
      chk("bp_next", 64'(ifa.dout), 64'h22);
      chk("bp_rdy1", 64'(ifa.dout_rdy), 64'd1);
      idle(3);
      chk("bp_a0", 64'(gota[0]), 64'h11);
      chk("bp_a1", 64'(gota[1]), 64'h22);
      chk("bp_b0", 64'(gotb[0]), 64'h88);
      chk("bp_b1", 64'(gotb[1]), 64'h44);

      // reset mid-word discards partial bits
      clear_got();
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b0, 1'b1, acc);
      send_word(8'hFF);
      idle(3);
      chk("rst_cnt", 64'(gota.size()), 64'd1);
      chk("rst_word", 64'(gota[0]), 64'hFF);

      // din_vld gaps between bits
      clear_got();
      pre = 8'hA5;
      for (int i = 0; i < W; i++) begin
         send_bit(pre[i], 1'b0);
         idle(1);
      end
      idle(2);
      chk("gap_cnt", 64'(gota.size()), 64'd1);
      chk("gap_a", 64'(gota[0]), 64'hA5);

`ifdef SER_2_PAR_FLUSH_EN
      clear_got();
      send_bit(1'b1, 1'b0);
      send_bit(1'b1, 1'b0);
      send_bit(1'b0, 1'b1);
      idle(2);
      send_word(8'h5A);
      idle(3);
      chk("fl_a0", 64'(gota[0]), 64'h03);
      chk("fl_b0", 64'(gotb[0]), 64'hC0);
      chk("fl_a1", 64'(gota[1]), 64'h5A);
`endif

      // randomized traffic with random backpressure
      for (int i = 0; i < 600 && !stuck; i++) begin
         bit d, v, l, r;
         rdy_drv = ($urandom_range(0, 3) != 0);
         d = 1'($urandom);
         v = ($urandom_range(0, 3) != 0);
         r = ($urandom_range(0, 249) == 0);
         l = 1'b0;
`ifdef SER_2_PAR_FLUSH_EN
         l = ($urandom_range(0, 9) == 0);
`endif
         cycle(d, v, l, r, acc);
      end

      rdy_drv = 1'b1;
      idle(2 * W + 4);
      chk("drain_a", 64'(expa.size()), 64'd0);
      chk("drain_b", 64'(expb.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
